// File: rtl/rv_pkg.sv
// rv_pkg: types and constants shared by the fetch stage and its neighbours.
package rv_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with synchronous flush and an occupancy count.
// The head is read straight from storage, so a push becomes visible one cycle later.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // A pop on empty is ignored; a push on full is legal only alongside a pop.
  assign pop_s  = pop & (count_r != '0);
  assign push_s = push & ((count_r != FULL_CNT) | pop_s);
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy; flush empties the queue without touching storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited in-order instruction fetch, decode FIFO and branch redirect.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned taken target sets misalign_err and halts fetch.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  branch,
  input  logic                  EQ,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t            state_r;
  logic [DATA_WIDTH-1:0]   pc_r;
  logic [DATA_WIDTH-1:0]   target_s;
  logic [DATA_WIDTH-1:0]   tag_head_s;
  logic [2*DATA_WIDTH-1:0] instr_head_s;
  logic [CW-1:0]           discard_r;
  logic [CW-1:0]           discard_n_s;
  logic [CW-1:0]           fifo_count_s;
  logic [CW-1:0]           tag_count_s;
  logic                    acc_s;
  logic                    taken_s;
  logic                    ret_live_s;
  logic                    ret_disc_s;
  logic                    credit_s;
  logic                    misalign_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_r;

  assign target_s     = branch_target;
  assign misalign_s   = (branch_target[1:0] != 2'b00);
  assign misalign_err = misalign_r;
`else
  assign target_s     = branch_target & ~(DATA_WIDTH'(2'b11));
  assign misalign_s   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // The tag queue holds exactly the live outstanding fetches, so its count is the inflight credit.
  assign credit_s   = ((CW+1)'(fifo_count_s) + (CW+1)'(tag_count_s) + (CW+1)'(discard_r))
                      < (CW+1)'(DEPTH);
  assign imem_req   = ~rst & (state_r == RUN) & credit_s;
  assign imem_addr  = pc_r;
  assign acc_s      = imem_req & imem_ready;
  assign taken_s    = branch & EQ;
  assign ret_disc_s = imem_rvalid & (discard_r != '0);
  assign ret_live_s = imem_rvalid & (discard_r == '0);

  assign instr_valid = (fifo_count_s != '0);
  assign instr       = instr_head_s[2*DATA_WIDTH-1:DATA_WIDTH];
  assign instr_pc    = instr_head_s[DATA_WIDTH-1:0];

  // Stale responses still owed by memory after a redirect
  always_comb begin
    discard_n_s = discard_r;
    if (taken_s) begin
      discard_n_s = discard_r + tag_count_s + CW'(acc_s) - CW'(imem_rvalid);
    end else if (ret_disc_s) begin
      discard_n_s = discard_r - CW'(1'b1);
    end else begin
      discard_n_s = discard_r;
    end
  end

  // PC, discard credit and run/halt state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      discard_r  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      discard_r <= discard_n_s;
      if (taken_s) begin
        pc_r <= target_s;
      end else if (acc_s) begin
        pc_r <= pc_r + DATA_WIDTH'(PC_STEP);
      end else begin
        pc_r <= pc_r;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (taken_s & misalign_s) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
`endif
      case (state_r)
        RUN:     state_r <= (taken_s & misalign_s) ? HALT : RUN;
        HALT:    state_r <= HALT;
        default: state_r <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (taken_s),
    .push      (acc_s),
    .push_data (pc_r),
    .pop       (ret_live_s),
    .head      (tag_head_s),
    .count     (tag_count_s)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_WIDTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (taken_s),
    .push      (ret_live_s),
    .push_data ({imem_rdata, tag_head_s}),
    .pop       (instr_ready),
    .head      (instr_head_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed fetch traffic checked against a queue-level model
// of outstanding memory requests and the decode FIFO.
module tb_fetch_unit;

  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          branch = 1'b0;
  logic          EQ = 1'b0;
  logic [DW-1:0] branch_target = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [DW-1:0] instr_pc;
  logic          instr_ready = 1'b0;
  logic          misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH (DW),
    .RESET_PC   (RPC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .EQ            (EQ),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .misalign_err  (misalign_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    int          due;
    logic        stale;
  } mreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fent_t;

  mreq_t       memq[$];
  fent_t       fifoq[$];
  logic [31:0] pc_m;
  bit          halted_m;
  bit          misalign_m;
  int          cyc;
  int          last_due;
  int          errors;
  int          checks;

  int rdy_pct[6] = '{100, 70, 50, 90, 30, 80};
  int ir_pct[6]  = '{100, 60, 30, 0, 90, 50};
  int br_pct[6]  = '{10, 20, 15, 25, 30, 5};
  int lat_max[6] = '{1, 3, 5, 2, 4, 6};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a falling edge; memory is reset alongside the fetch unit.
  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; branch = 1'b0; EQ = 1'b0; instr_ready = 1'b0;
    memq.delete();
    fifoq.delete();
    pc_m = RPC; halted_m = 1'b0; misalign_m = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_imem_addr", imem_addr, RPC);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_misalign", misalign_err, 1'b0);
    rst = 1'b0;
    last_due = cyc;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit ir, input bit br, input bit eq,
                      input logic [31:0] tgt, input int lat);
    bit    req, acc, ret, taken, live;
    mreq_t m;
    fent_t f;
    int    due;
    #1;
    req = !halted_m && (fifoq.size() + memq.size() < DEPTH);
    check_eq("imem_req", imem_req, req);
    check_eq("imem_addr", imem_addr, pc_m);
    check_eq("instr_valid", instr_valid, fifoq.size() != 0);
    if (fifoq.size() != 0) begin
      check_eq("instr", instr, fifoq[0].data);
      check_eq("instr_pc", instr_pc, fifoq[0].pc);
    end
    check_eq("misalign_err", misalign_err, misalign_m);

    ret = (memq.size() != 0) && (memq[0].due <= cyc);
    imem_ready    = rdy;
    imem_rvalid   = ret;
    imem_rdata    = ret ? mem_word(memq[0].addr) : $urandom();
    instr_ready   = ir;
    branch        = br;
    EQ            = eq;
    branch_target = tgt;

    acc   = req && rdy;
    taken = br && eq;
    live  = 1'b0;
    f     = '0;
    due   = 0;
    if (acc) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
    end
    if (ret) begin
      m      = memq.pop_front();
      live   = !m.stale;
      f.data = mem_word(m.addr);
      f.pc   = m.addr;
    end
    if (taken) begin
      fifoq.delete();
      for (int i = 0; i < memq.size(); i++) begin
        m = memq[i];
        m.stale = 1'b1;
        memq[i] = m;
      end
      if (acc) memq.push_back('{addr: pc_m, due: due, stale: 1'b1});
`ifdef FETCH_ALIGN_CHECK_EN
      pc_m = tgt;
      if (tgt[1:0] != 2'b00) begin
        halted_m   = 1'b1;
        misalign_m = 1'b1;
      end
`else
      pc_m = tgt & 32'hFFFF_FFFC;
`endif
    end else begin
      if (ir && fifoq.size() != 0) void'(fifoq.pop_front());
      if (live) fifoq.push_back(f);
      if (acc) begin
        memq.push_back('{addr: pc_m, due: due, stale: 1'b0});
        pc_m = pc_m + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
`ifdef FETCH_ALIGN_CHECK_EN
      2:       return $urandom() & 32'hFFFF_FFFC;
      default: return 32'h0000_0200;
`else
      2:       return $urandom();
      default: return 32'h0000_0102;
`endif
    endcase
  endfunction

  initial begin
    errors = 0; checks = 0; cyc = 0; last_due = 0;
    do_reset();

    // Single-cycle memory, decode always ready
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    // Decode stalled: credit exhausted, then resume
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    // Slow memory with a redirect while requests are in flight
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3);
    // PC wrap past the top of the address space
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);

    for (int p = 0; p < 6; p++) begin
      if (p == 3) do_reset();
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(99) < rdy_pct[p], $urandom_range(99) < ir_pct[p],
             $urandom_range(99) < br_pct[p], $urandom_range(1) == 1,
             pick_target(), $urandom_range(lat_max[p], 1));
      end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned target halts fetch until reset
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 2);
    repeat (12) step($urandom_range(1) == 1, $urandom_range(1) == 1, 1'b0, 1'b0, 32'h0, 2);
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
